life_grid_scanner: RTL

// Parametrised successor to the Life control block: loads a preset pattern into the external

---
 rtl/life_grid_scanner_if.sv | 39 +++
 rtl/life_grid_scanner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_scanner_if.sv
// Bundle of the scanner's control, cell-RAM and pixel-plot signals.
// master: the scanner itself. slave: the environment (keys, RAM, plotter).
interface life_grid_scanner_if #(
  parameter int COLS       = 40,
  parameter int ROW_AW     = 5,
  parameter int COL_AW     = 6,
  parameter int CELL_SHIFT = 2,
  parameter int COLOR_W    = 3
);
  // Control from the user keys / generation engine
  logic                         go;
  logic                         preset_load;
  logic [2:0]                   preset_sel;
  logic                         busy;

  // Cell RAM port (synchronous read, one cycle latency)
  logic [ROW_AW-1:0]            mem_addr;
  logic [COLS-1:0]              mem_wdata;
  logic                         mem_we;
  logic [COLS-1:0]              mem_rdata;

  // Pixel plot handshake towards the VGA adapter
  logic [COL_AW+CELL_SHIFT-1:0] x;
  logic [ROW_AW+CELL_SHIFT-1:0] y;
  logic [COLOR_W-1:0]           colour;
  logic                         plot;
  logic                         plot_ready;
  logic                         frame_done;

  modport master (
    input  go, preset_load, preset_sel, mem_rdata, plot_ready,
    output busy, mem_addr, mem_wdata, mem_we, x, y, colour, plot, frame_done
  );

  modport slave (
    output go, preset_load, preset_sel, mem_rdata, plot_ready,
    input  busy, mem_addr, mem_wdata, mem_we, x, y, colour, plot, frame_done
  );
endinterface

// File: rtl/life_grid_scanner.sv
// Life grid scanner: writes a preset pattern into the ROWS x COLS cell RAM and
// scans the RAM out as 2^CELL_SHIFT square pixel blocks over a ready handshake.
// Column 0 of a row lives in bit COLS-1 of the RAM word.
module life_grid_scanner #(
  parameter int                 COLS         = 40,
  parameter int                 ROWS         = 30,
  parameter int                 ROW_AW       = 5,
  parameter int                 COL_AW       = 6,
  parameter int                 CELL_SHIFT   = 2,
  parameter int                 COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] ALIVE_COLOR  = 3'b111,
  parameter logic [COLOR_W-1:0] DEAD_COLOR   = 3'b000,
  parameter bit                 AUTO_REFRESH = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  life_grid_scanner_if.master bus
);

  // Pattern anchors: centre column / centre row offsets used by the presets
  localparam int CC = (COLS - 5) / 2;
  localparam int RC = ROWS / 2 - 2;

  // Counter limits; every counter wraps by comparing against these
  localparam logic [CELL_SHIFT-1:0] PIX_MAX = '1;
  localparam logic [COL_AW-1:0]     COL_MAX = COL_AW'(COLS - 1);
  localparam logic [ROW_AW-1:0]     ROW_MAX = ROW_AW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_REQ,
    S_RD_WAIT,
    S_PLOT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [ROW_AW-1:0]      row;
  logic [COL_AW-1:0]      col;
  logic [CELL_SHIFT-1:0]  px;
  logic [CELL_SHIFT-1:0]  py;
  logic [2:0]             sel_q;
  logic [COLS-1:0]        row_q;

  logic                   busy_r;
  logic [ROW_AW-1:0]      mem_addr_r;
  logic [COLS-1:0]        mem_wdata_r;
  logic                   mem_we_r;
  logic                   plot_r;
  logic [COLOR_W-1:0]     colour_r;
  logic                   frame_done_r;

  // Place a w-bit pattern (MSB first) so its first bit lands on column c0
  function automatic logic [COLS-1:0] place(input logic [7:0] pat, input int w, input int c0);
    return COLS'(pat) << (COLS - c0 - w);
  endfunction

  // RAM word for row r of preset sel; unknown selections clear the grid
  function automatic logic [COLS-1:0] preset_row(input logic [2:0] sel, input int r);
    logic [COLS-1:0] v;
    v = '0;
    case (sel)
      3'd1: begin
        if (r == 0)      v = place(8'b100, 3, 0);
        else if (r == 1) v = place(8'b011, 3, 0);
        else if (r == 2) v = place(8'b110, 3, 0);
      end
      3'd2: begin
        if (r == RC || r == RC + 4)  v = place(8'b10101, 5, CC);
        else if (r > RC && r < RC + 4) v = place(8'b10001, 5, CC);
      end
      3'd3: begin
        if (r == RC || r == RC + 1)          v = place(8'b11011, 5, CC);
        else if (r == RC + 2)                v = place(8'b01010, 5, CC);
        else if (r == RC + 3 || r == RC + 4) v = place(8'b1010101, 7, CC - 1);
        else if (r == RC + 5)                v = place(8'b1100011, 7, CC - 1);
      end
      3'd4: begin
        if (r == RC)          v = place(8'b001111, 6, 0);
        else if (r == RC + 1) v = place(8'b010001, 6, 0);
        else if (r == RC + 2) v = place(8'b000001, 6, 0);
        else if (r == RC + 3) v = place(8'b010010, 6, 0);
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Colour of column c within a row word (column 0 is the MSB)
  function automatic logic [COLOR_W-1:0] cell_colour(input logic [COLS-1:0] word,
                                                      input logic [COL_AW-1:0] c);
    logic [COLS-1:0] sh;
    sh = word << c;
    return sh[COLS-1] ? ALIVE_COLOR : DEAD_COLOR;
  endfunction

  // Row buffer: captures the RAM word as the read completes; pure data, no reset
  always_ff @(posedge clk) begin
    if (state == S_RD_WAIT) row_q <= bus.mem_rdata;
  end

  // Main controller: state, scan counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      px           <= '0;
      py           <= '0;
      sel_q        <= '0;
      busy_r       <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      mem_we_r     <= 1'b0;
      plot_r       <= 1'b0;
      colour_r     <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // Preset load has priority; a simultaneous go is dropped
          if (bus.preset_load) begin
            state       <= S_LOAD;
            sel_q       <= bus.preset_sel;
            row         <= '0;
            busy_r      <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= '0;
            mem_wdata_r <= preset_row(bus.preset_sel, 0);
          end else if (bus.go) begin
            state      <= S_RD_REQ;
            row        <= '0;
            col        <= '0;
            px         <= '0;
            py         <= '0;
            busy_r     <= 1'b1;
            mem_addr_r <= '0;
          end
        end

        S_LOAD: begin
          if (row == ROW_MAX) begin
            row         <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            col         <= '0;
            px          <= '0;
            py          <= '0;
            if (AUTO_REFRESH) begin
              state <= S_RD_REQ;
            end else begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
            end
          end else begin
            row         <= row + ROW_AW'(1);
            mem_addr_r  <= row + ROW_AW'(1);
            mem_wdata_r <= preset_row(sel_q, int'(row) + 1);
          end
        end

        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          // Read data arrives now; first pixel of the row is presented next cycle
          state    <= S_PLOT;
          plot_r   <= 1'b1;
          colour_r <= cell_colour(bus.mem_rdata, '0);
        end

        S_PLOT: begin
          if (bus.plot_ready) begin
            if (px != PIX_MAX) begin
              px <= px + CELL_SHIFT'(1);
            end else begin
              px <= '0;
              if (py != PIX_MAX) begin
                py <= py + CELL_SHIFT'(1);
              end else begin
                py <= '0;
                if (col != COL_MAX) begin
                  col      <= col + COL_AW'(1);
                  colour_r <= cell_colour(row_q, col + COL_AW'(1));
                end else begin
                  col    <= '0;
                  plot_r <= 1'b0;
                  if (row != ROW_MAX) begin
                    row        <= row + ROW_AW'(1);
                    mem_addr_r <= row + ROW_AW'(1);
                    state      <= S_RD_REQ;
                  end else begin
                    row          <= '0;
                    mem_addr_r   <= '0;
                    frame_done_r <= 1'b1;
                    state        <= S_DONE;
                  end
                end
              end
            end
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          busy_r   <= 1'b0;
          mem_we_r <= 1'b0;
          plot_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.x          = {col, px};
  assign bus.y          = {row, py};
  assign bus.colour     = colour_r;
  assign bus.plot       = plot_r;
  assign bus.frame_done = frame_done_r;

endmodule
